out_serial_port: RTL and testbench



---
 rtl/out_serial_port_pkg.sv | 19 +
 rtl/out_serial_port_if.sv | 27 ++
 rtl/out_serial_port_byte_fifo.sv | 67 ++++++
 rtl/out_serial_port.sv | 128 ++++++++++++
 tb/tb_out_serial_port.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/out_serial_port_pkg.sv
// rtl/out_serial_port_pkg.sv - shared types, defaults and helpers for the serial output port
package out_port_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int DEFAULT_FIFO_DEPTH = 4;
    localparam int DEFAULT_BAUD_DIV   = 4;

    // Occupancy needs one extra bit so that "full" (count == depth) is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/out_serial_port_if.sv
// rtl/out_serial_port_if.sv - dbus/doOut input and serial/status outputs of the output port
interface out_serial_port_if
    import out_port_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
);
    localparam int CW = count_width(FIFO_DEPTH);

    logic          doOut;
    logic [7:0]    dbus;
    logic          txd;
    logic          busy;
    logic          full;
    logic          overflow;
    logic [CW-1:0] count;

    modport master (
        output doOut, dbus,
        input  txd, busy, full, overflow, count
    );

    modport slave (
        input  doOut, dbus,
        output txd, busy, full, overflow, count
    );

endinterface

// File: rtl/out_serial_port_byte_fifo.sv
// rtl/out_serial_port_byte_fifo.sv - byte FIFO with occupancy count, push-when-full allowed with a pop
module byte_fifo
    import out_port_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [7:0]                   wdata_i,
    output logic [7:0]                   rdata_o,
    output logic [count_width(DEPTH)-1:0] count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_acc;
    logic          pop_acc;

    assign full_o   = (count_q == CW'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign rdata_o  = mem_q[rd_ptr_q];
    assign count_o  = count_q;
    // A full FIFO still takes a byte when the head leaves on the same edge.
    assign push_acc = push_i && (!full_o || pop_i);
    assign pop_acc  = pop_i && !empty_o;

    // Pointer and occupancy next-state; pointers wrap naturally at power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_acc)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers; reset discards any buffered bytes.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_acc) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/out_serial_port.sv
// rtl/out_serial_port.sv - captures doOut bytes into a FIFO and sends them as 8N1 serial on txd
module out_serial_port
    import out_port_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int BAUD_DIV   = DEFAULT_BAUD_DIV
) (
    input  logic              clk,
    input  logic              reset,
    out_serial_port_if.slave  bus
);
    localparam int CW = count_width(FIFO_DEPTH);
    localparam int DW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [DW-1:0] DIV_RELOAD = DW'(BAUD_DIV - 1);

    tx_state_e     state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          ovf_q, ovf_d;
    logic          pop;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (bus.doOut),
        .pop_i   (pop),
        .wdata_i (bus.dbus),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Transmitter next-state: divider counts down to 0, then the bit/state advances; txd is precomputed.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    div_d   = DIV_RELOAD;
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (div_q == '0) begin
                    div_d   = DIV_RELOAD;
                    bit_d   = 3'd0;
                    state_d = DATA;
                    txd_d   = shift_q[0];
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            DATA: begin
                if (div_q == '0) begin
                    div_d = DIV_RELOAD;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            STOP: begin
                txd_d = 1'b1;
                if (div_q == '0) begin
                    state_d = IDLE;
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
        // A byte is lost only when the FIFO is full and nothing leaves this edge.
        ovf_d = ovf_q | (bus.doOut & fifo_full & ~pop);
    end

    // Transmitter and overflow registers; reset forces the line idle-high immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.txd      = txd_q;
    assign bus.busy     = (state_q != IDLE) || !fifo_empty;
    assign bus.full     = fifo_full;
    assign bus.overflow = ovf_q;
    assign bus.count    = fifo_count;

endmodule

// File: tb/tb_out_serial_port.sv
// tb/tb_out_serial_port.sv - scoreboard bench for out_serial_port
module tb_out_serial_port;
    localparam int DEPTH = 4;
    localparam int BAUD  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    out_serial_port_if #(.FIFO_DEPTH(DEPTH)) tb_if();

    out_serial_port #(
        .FIFO_DEPTH (DEPTH),
        .BAUD_DIV   (BAUD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tb_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;
    byte unsigned exp_q[$];
    int starts[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic d, input logic [7:0] data);
        tb_if.doOut = d;
        tb_if.dbus  = data;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((tb_if.busy || exp_q.size() != 0) && n < bound);
        repeat (2) tick();
        check({"idle_", tag}, {31'b0, tb_if.busy}, 0);
        check({"drained_", tag}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_txd", {31'b0, tb_if.txd}, 1);
        check("rst_count", {29'b0, tb_if.count}, 0);
        check("rst_busy", {31'b0, tb_if.busy}, 0);
        check("rst_full", {31'b0, tb_if.full}, 0);
        check("rst_overflow", {31'b0, tb_if.overflow}, 0);
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // Monitor: recover each frame cycle by cycle and compare to the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && tb_if.txd === 1'b0) begin
                logic [9:0] frame;
                logic [9:0] rx;
                logic [7:0] b;
                logic       bad;
                logic       aborted;
                starts.push_back(cyc);
                check("frame_expected", {31'b0, exp_q.size() > 0}, 1);
                b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                frame   = {1'b1, b, 1'b0};
                rx      = '0;
                bad     = 1'b0;
                aborted = 1'b0;
                for (int c = 0; c < 10 * BAUD; c++) begin
                    if (c != 0) @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (tb_if.txd !== frame[c / BAUD]) bad = 1'b1;
                    if (c % BAUD == BAUD / 2) rx[c / BAUD] = tb_if.txd;
                end
                if (!aborted) check($sformatf("frame_%02h", b), {21'b0, bad, rx}, {22'b0, frame});
            end
        end
    end

    initial begin
        int errs;
        int peak;
        drive(1'b0, 8'h00);
        repeat (3) tick();
        check("init_txd", {31'b0, tb_if.txd}, 1);
        check("init_busy", {31'b0, tb_if.busy}, 0);
        check("init_count", {29'b0, tb_if.count}, 0);
        check("init_full", {31'b0, tb_if.full}, 0);
        check("init_overflow", {31'b0, tb_if.overflow}, 0);
        reset = 1'b0;

        errs = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tb_if.txd !== 1'b1 || tb_if.busy !== 1'b0 || tb_if.count !== '0) errs++;
        end
        check("idle_50_cycles", errs, 0);

        // Single byte: latency and exact bit timing
        tick(); drive(1'b1, 8'hA5); exp_q.push_back(8'hA5);
        tick(); drive(1'b0, 8'h00);
        check("lat_count_1", {29'b0, tb_if.count}, 1);
        check("lat_txd_still_high", {31'b0, tb_if.txd}, 1);
        tick();
        check("lat_txd_low", {31'b0, tb_if.txd}, 0);
        check("lat_count_0", {29'b0, tb_if.count}, 0);
        wait_idle("a5", 100);

        // Four back-to-back bytes: peak occupancy and start spacing
        starts.delete();
        peak = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (int'(tb_if.count) > peak) peak = int'(tb_if.count);
            drive(1'b1, 8'(i + 1));
            exp_q.push_back(8'(i + 1));
        end
        tick();
        if (int'(tb_if.count) > peak) peak = int'(tb_if.count);
        drive(1'b0, 8'h00);
        wait_idle("burst4", 300);
        check("burst4_peak", peak, 3);
        check("burst4_frames", starts.size(), 4);
        for (int i = 1; i < starts.size(); i++)
            check($sformatf("burst4_spacing_%0d", i), starts[i] - starts[i-1], 10 * BAUD + 1);
        check("burst4_overflow", {31'b0, tb_if.overflow}, 0);

        // Six bytes: the sixth is dropped and overflow latches
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 5) check("six_full", {31'b0, tb_if.full}, 1);
            drive(1'b1, 8'(8'h10 + i));
            if (i < 5) exp_q.push_back(8'(8'h10 + i));
        end
        tick(); drive(1'b0, 8'h00);
        check("six_overflow", {31'b0, tb_if.overflow}, 1);
        check("six_count", {29'b0, tb_if.count}, 4);
        wait_idle("six", 500);
        check("six_overflow_sticky", {31'b0, tb_if.overflow}, 1);

        // Push into a full FIFO on the same edge as an IDLE pop
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(); drive(1'b1, 8'(8'h20 + i)); exp_q.push_back(8'(8'h20 + i));
        end
        repeat (37) begin
            tick(); drive(1'b0, 8'h00);
        end
        tick();
        check("fp_pre_count", {29'b0, tb_if.count}, 4);
        check("fp_pre_full", {31'b0, tb_if.full}, 1);
        drive(1'b1, 8'h25); exp_q.push_back(8'h25);
        tick(); drive(1'b0, 8'h00);
        check("fp_count", {29'b0, tb_if.count}, 4);
        check("fp_overflow", {31'b0, tb_if.overflow}, 0);
        wait_idle("fullpop", 600);

        // Reset mid-DATA with bytes queued, then a clean frame
        do_reset();
        tick(); drive(1'b1, 8'hFF); exp_q.push_back(8'hFF);
        tick(); drive(1'b1, 8'h5A);
        tick(); drive(1'b1, 8'h66);
        tick(); drive(1'b0, 8'h00);
        check("mid_queued", {29'b0, tb_if.count}, 2);
        repeat (10) tick();
        #2 reset = 1'b1;
        #1;
        check("mid_txd", {31'b0, tb_if.txd}, 1);
        check("mid_count", {29'b0, tb_if.count}, 0);
        check("mid_busy", {31'b0, tb_if.busy}, 0);
        repeat (2) tick();
        reset = 1'b0;
        tick(); drive(1'b1, 8'h3C); exp_q.push_back(8'h3C);
        tick(); drive(1'b0, 8'h00);
        wait_idle("3c", 200);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
